// File: rtl/grid_frame_streamer.sv
// Expands packed 1-bit-per-cell grid rows into a scaled RGB AXI4-Stream, double-buffering rows from BRAM.
// Optional gridline overlay: define GRID_FRAME_STREAMER_GRIDLINES_EN.
module grid_frame_streamer #(
  parameter int          GRID_W      = 1280,
  parameter int          GRID_H      = 720,
  parameter int          SCALE_X     = 1,
  parameter int          SCALE_Y     = 1,
  parameter int          MEM_LATENCY = 1,
  parameter logic [23:0] ALIVE_RGB   = 24'hCB416B,
  parameter logic [23:0] DEAD_RGB    = 24'h000000
`ifdef GRID_FRAME_STREAMER_GRIDLINES_EN
  ,
  parameter logic [23:0] LINE_RGB    = 24'h202020
`endif
) (
  input  logic                                           out_stream_aclk,
  input  logic                                           periph_reset,
  input  logic                                           start,
  output logic                                           row_rd_en,
  output logic [((GRID_H > 1) ? $clog2(GRID_H) : 1)-1:0] row_addr,
  input  logic [GRID_W-1:0]                              row_data,
  output logic [23:0]                                    out_tdata,
  output logic                                           out_tvalid,
  input  logic                                           out_tready,
  output logic                                           out_tuser,
  output logic                                           out_tlast,
  output logic                                           busy,
  output logic                                           frame_done
);

  localparam int AW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int CXW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int FCW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  localparam logic [CXW-1:0] CX_MAX = CXW'(GRID_W - 1);
  localparam logic [SXW-1:0] SX_MAX = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0] SY_MAX = SYW'(SCALE_Y - 1);
  localparam logic [AW-1:0]  GY_MAX = AW'(GRID_H - 1);
  localparam logic [FCW-1:0] FC_MAX = FCW'(MEM_LATENCY);

  if (GRID_W * SCALE_X < MEM_LATENCY + 2) begin : g_cfg_check
    $error("grid_frame_streamer: GRID_W*SCALE_X must be >= MEM_LATENCY+2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_STREAM  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_q;
  logic [SXW-1:0]  sx_q, sx_d;
  logic [CXW-1:0]  cx_q, cx_d;
  logic [SYW-1:0]  sy_q, sy_d;
  logic [AW-1:0]   gy_q, gy_d;
  logic            buf_sel_q, buf_sel_d;
  logic [GRID_W-1:0] buf_q [0:1];
  logic            fetch_pend_q;
  logic [FCW-1:0]  fetch_cnt_q;
  logic            fetch_buf_q;
  logic            row_rd_en_q;
  logic [AW-1:0]   row_addr_q;
  logic [23:0]     out_tdata_q;
  logic            out_tvalid_q, out_tuser_q, out_tlast_q;
  logic            busy_q, frame_done_q;

  logic            hs_s, line_end_s, row_end_s, frame_end_s, prefetch_s, cap_s, use_next_s;
  logic [SXW-1:0]  nxt_sx_s;
  logic [CXW-1:0]  nxt_cx_s;
  logic [SYW-1:0]  nxt_sy_s;
  logic [AW-1:0]   nxt_gy_s;
  logic            nxt_sel_s;
  logic [GRID_W-1:0] row_view_s;
  logic [23:0]     cell_rgb_s, nxt_tdata_s;
  logic            nxt_tuser_s, nxt_tlast_s;

  assign row_rd_en  = row_rd_en_q;
  assign row_addr   = row_addr_q;
  assign out_tdata  = out_tdata_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tuser  = out_tuser_q;
  assign out_tlast  = out_tlast_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Position counters after the current beat, wrapping sx -> cx -> sy -> gy.
  always_comb begin
    sx_d = sx_q;
    cx_d = cx_q;
    sy_d = sy_q;
    gy_d = gy_q;
    if (sx_q != SX_MAX) begin
      sx_d = sx_q + SXW'(1);
    end else begin
      sx_d = {SXW{1'b0}};
      if (cx_q != CX_MAX) begin
        cx_d = cx_q + CXW'(1);
      end else begin
        cx_d = {CXW{1'b0}};
        if (sy_q != SY_MAX) begin
          sy_d = sy_q + SYW'(1);
        end else begin
          sy_d = {SYW{1'b0}};
          if (gy_q != GY_MAX) begin
            gy_d = gy_q + AW'(1);
          end else begin
            gy_d = {AW{1'b0}};
          end
        end
      end
    end
  end

  // Handshake, end-of-line/row/frame and prefetch decode for the beat on the bus.
  always_comb begin
    hs_s        = out_tvalid_q & out_tready;
    line_end_s  = (sx_q == SX_MAX) && (cx_q == CX_MAX);
    row_end_s   = line_end_s && (sy_q == SY_MAX);
    frame_end_s = row_end_s && (gy_q == GY_MAX);
    prefetch_s  = hs_s && (sx_q == {SXW{1'b0}}) && (cx_q == {CXW{1'b0}})
                  && (sy_q == {SYW{1'b0}}) && (gy_q != GY_MAX);
    buf_sel_d   = row_end_s ? ~buf_sel_q : buf_sel_q;
    cap_s       = fetch_pend_q && (fetch_cnt_q == FC_MAX);
  end

  // Next pixel to present; a row landing this very cycle is forwarded straight from row_data.
  always_comb begin
    use_next_s  = (state_q == S_STREAM);
    nxt_sx_s    = use_next_s ? sx_d : sx_q;
    nxt_cx_s    = use_next_s ? cx_d : cx_q;
    nxt_sy_s    = use_next_s ? sy_d : sy_q;
    nxt_gy_s    = use_next_s ? gy_d : gy_q;
    nxt_sel_s   = use_next_s ? buf_sel_d : buf_sel_q;
    row_view_s  = (cap_s && (fetch_buf_q == nxt_sel_s)) ? row_data : buf_q[nxt_sel_s];
    cell_rgb_s  = row_view_s[CX_MAX - nxt_cx_s] ? ALIVE_RGB : DEAD_RGB;
`ifdef GRID_FRAME_STREAMER_GRIDLINES_EN
    nxt_tdata_s = (((SCALE_X >= 2) && (nxt_sx_s == {SXW{1'b0}}))
                   || ((SCALE_Y >= 2) && (nxt_sy_s == {SYW{1'b0}}))) ? LINE_RGB : cell_rgb_s;
`else
    nxt_tdata_s = cell_rgb_s;
`endif
    nxt_tuser_s = (nxt_sx_s == {SXW{1'b0}}) && (nxt_cx_s == {CXW{1'b0}})
                  && (nxt_sy_s == {SYW{1'b0}}) && (nxt_gy_s == {AW{1'b0}});
    nxt_tlast_s = (nxt_sx_s == SX_MAX) && (nxt_cx_s == CX_MAX);
  end

  // Frame FSM, row fetch/capture and all registered outputs.
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state_q      <= S_IDLE;
      sx_q         <= {SXW{1'b0}};
      cx_q         <= {CXW{1'b0}};
      sy_q         <= {SYW{1'b0}};
      gy_q         <= {AW{1'b0}};
      buf_sel_q    <= 1'b0;
      buf_q[0]     <= {GRID_W{1'b0}};
      buf_q[1]     <= {GRID_W{1'b0}};
      fetch_pend_q <= 1'b0;
      fetch_cnt_q  <= {FCW{1'b0}};
      fetch_buf_q  <= 1'b0;
      row_rd_en_q  <= 1'b0;
      row_addr_q   <= {AW{1'b0}};
      out_tdata_q  <= 24'h000000;
      out_tvalid_q <= 1'b0;
      out_tuser_q  <= 1'b0;
      out_tlast_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_rd_en_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (cap_s) begin
        buf_q[fetch_buf_q] <= row_data;
        fetch_pend_q       <= 1'b0;
      end else if (fetch_pend_q) begin
        fetch_cnt_q <= fetch_cnt_q + FCW'(1);
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_PREFILL;
            busy_q       <= 1'b1;
            row_rd_en_q  <= 1'b1;
            row_addr_q   <= {AW{1'b0}};
            fetch_pend_q <= 1'b1;
            fetch_cnt_q  <= {FCW{1'b0}};
            fetch_buf_q  <= 1'b0;
            buf_sel_q    <= 1'b0;
            sx_q         <= {SXW{1'b0}};
            cx_q         <= {CXW{1'b0}};
            sy_q         <= {SYW{1'b0}};
            gy_q         <= {AW{1'b0}};
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PREFILL: begin
          // Row 0 has landed in buffer 0; present the first beat.
          if (!fetch_pend_q) begin
            state_q      <= S_STREAM;
            out_tvalid_q <= 1'b1;
            out_tdata_q  <= nxt_tdata_s;
            out_tuser_q  <= nxt_tuser_s;
            out_tlast_q  <= nxt_tlast_s;
          end else begin
            state_q <= S_PREFILL;
          end
        end
        S_STREAM: begin
          if (hs_s) begin
            sx_q      <= sx_d;
            cx_q      <= cx_d;
            sy_q      <= sy_d;
            gy_q      <= gy_d;
            buf_sel_q <= buf_sel_d;
            if (frame_end_s) begin
              state_q      <= S_DONE;
              out_tvalid_q <= 1'b0;
              out_tdata_q  <= 24'h000000;
              out_tuser_q  <= 1'b0;
              out_tlast_q  <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              out_tdata_q <= nxt_tdata_s;
              out_tuser_q <= nxt_tuser_s;
              out_tlast_q <= nxt_tlast_s;
            end
            if (prefetch_s) begin
              row_rd_en_q  <= 1'b1;
              row_addr_q   <= gy_q + AW'(1);
              fetch_pend_q <= 1'b1;
              fetch_cnt_q  <= {FCW{1'b0}};
              fetch_buf_q  <= ~buf_sel_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_frame_streamer.sv
// Directed self-checking bench for grid_frame_streamer: an 8x4 unscaled instance and an 8x4 2x2-scaled instance.
module tb_grid_frame_streamer;

  localparam int          L     = 1;
  localparam logic [23:0] ALIVE = 24'hCB416B;
  localparam logic [23:0] DEAD  = 24'h000000;
  localparam logic [23:0] GLINE = 24'h202020;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, tready_a = 1'b0, tready_b = 1'b0;
  logic        rd_en_a, rd_en_b;
  logic [1:0]  addr_a, addr_b;
  logic [7:0]  rdata_a = 8'h00, rdata_b = 8'h00;
  logic [23:0] tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b, tuser_a, tuser_b, tlast_a, tlast_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b [4];

  grid_frame_streamer #(.GRID_W(8), .GRID_H(4), .SCALE_X(1), .SCALE_Y(1), .MEM_LATENCY(L)) dut_a (
    .out_stream_aclk(clk), .periph_reset(rst), .start(start_a),
    .row_rd_en(rd_en_a), .row_addr(addr_a), .row_data(rdata_a),
    .out_tdata(tdata_a), .out_tvalid(tvalid_a), .out_tready(tready_a),
    .out_tuser(tuser_a), .out_tlast(tlast_a), .busy(busy_a), .frame_done(done_a));

  grid_frame_streamer #(.GRID_W(8), .GRID_H(4), .SCALE_X(2), .SCALE_Y(2), .MEM_LATENCY(L)) dut_b (
    .out_stream_aclk(clk), .periph_reset(rst), .start(start_b),
    .row_rd_en(rd_en_b), .row_addr(addr_b), .row_data(rdata_b),
    .out_tdata(tdata_b), .out_tvalid(tvalid_b), .out_tready(tready_b),
    .out_tuser(tuser_b), .out_tlast(tlast_b), .busy(busy_b), .frame_done(done_b));

  // One-cycle-latency frame BRAM models
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= mem_a[addr_a];
    if (rd_en_b) rdata_b <= mem_b[addr_b];
  end

  int checks = 0;
  int errors = 0;
  logic [25:0] beats [$];
  logic [1:0]  addrs [$];
  int rd_cnt, first_at, done_at, last_at;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {tuser, tlast, tdata} of beat k for the unscaled instance
  function automatic logic [25:0] exp_a(input logic [7:0] row, input int k);
    int c;
    c = k % 8;
    return {(k == 0), (c == 7), (row[7 - c] ? ALIVE : DEAD)};
  endfunction

  function automatic logic [25:0] exp_b(input int k);
    int line, px, gy, sy, cx, sx;
    logic [7:0]  row;
    logic [23:0] col;
    line = k / 16; px = k % 16; gy = line / 2; sy = line % 2; cx = px / 2; sx = px % 2;
    row = mem_b[gy];
    col = row[7 - cx] ? ALIVE : DEAD;
`ifdef GRID_FRAME_STREAMER_GRIDLINES_EN
    if (sx == 0 || sy == 0) col = GLINE;
`endif
    return {(k == 0), (px == 15), col};
  endfunction

  task automatic run_b();
    beats.delete();
    rd_cnt = 0; first_at = -1; done_at = -1; last_at = -1;
    tready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int cyc = 0; cyc < 400 && done_at < 0; cyc++) begin
      if (rd_en_b) rd_cnt++;
      if (tvalid_b && first_at < 0) first_at = cyc;
      if (done_b) done_at = cyc;
      if (tvalid_b && tready_b) begin
        beats.push_back({tuser_b, tlast_b, tdata_b});
        last_at = cyc;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({tvalid_a, tuser_a, tlast_a, busy_a, done_a, rd_en_a} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_a: got %b expected 000000", {tvalid_a, tuser_a, tlast_a, busy_a, done_a, rd_en_a});
    end
    checks++;
    if ({tvalid_b, tuser_b, tlast_b, busy_b, done_b, rd_en_b} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_b: got %b expected 000000", {tvalid_b, tuser_b, tlast_b, busy_b, done_b, rd_en_b});
    end
    checks++;
    if ({tdata_a, tdata_b} !== 48'h0) begin
      errors++; $display("FAIL reset_tdata: got %h expected 0", {tdata_a, tdata_b});
    end
    checks++;
    if ({addr_a, addr_b} !== 4'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", {addr_a, addr_b});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame_basic();
    for (int i = 0; i < 4; i++) mem_a[i] = 8'b1000_0001;
    beats.delete(); addrs.delete();
    rd_cnt = 0; first_at = -1; done_at = -1; last_at = -1;
    tready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int cyc = 0; cyc < 200 && done_at < 0; cyc++) begin
      if (rd_en_a) begin rd_cnt++; addrs.push_back(addr_a); end
      if (tvalid_a && first_at < 0) first_at = cyc;
      if (done_a) done_at = cyc;
      if (tvalid_a && tready_a) begin
        beats.push_back({tuser_a, tlast_a, tdata_a});
        last_at = cyc;
      end
      tick();
    end
    checks++;
    if (first_at != L + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", first_at, L + 2); end
    checks++;
    if (beats.size() != 32) begin errors++; $display("FAIL basic_beat_count: got %0d expected 32", beats.size()); end
    for (int k = 0; k < beats.size(); k++) begin
      checks++;
      if (beats[k] !== exp_a(mem_a[k / 8], k)) begin
        errors++; $display("FAIL basic_beat %0d: got %h expected %h", k, beats[k], exp_a(mem_a[k / 8], k));
      end
    end
    checks++;
    if (done_at < 0 || done_at != last_at + 1) begin
      errors++; $display("FAIL basic_frame_done: got cycle %0d expected %0d", done_at, last_at + 1);
    end
    checks++;
    if (rd_cnt != 4) begin errors++; $display("FAIL basic_rd_pulses: got %0d expected 4", rd_cnt); end
    for (int i = 0; i < addrs.size(); i++) begin
      checks++;
      if (addrs[i] !== i[1:0]) begin errors++; $display("FAIL basic_row_addr %0d: got %0d expected %0d", i, addrs[i], i); end
    end
  endtask

  task automatic test_backpressure();
    logic        held;
    logic [25:0] held_val;
    mem_a[0] = 8'h01; mem_a[1] = 8'h02; mem_a[2] = 8'h04; mem_a[3] = 8'h08;
    beats.delete();
    rd_cnt = 0; done_at = -1; held = 1'b0; held_val = 26'h0;
    start_a = 1'b1;
    tready_a = 1'b0;
    tick();
    start_a = 1'b0;
    for (int cyc = 0; cyc < 400 && done_at < 0; cyc++) begin
      if (held) begin
        checks++;
        if ({tvalid_a, tuser_a, tlast_a, tdata_a} !== {1'b1, held_val}) begin
          errors++; $display("FAIL stall_hold cyc %0d: got %h expected %h", cyc, {tvalid_a, tuser_a, tlast_a, tdata_a}, {1'b1, held_val});
        end
      end
      if (rd_en_a) rd_cnt++;
      if (done_a) done_at = cyc;
      tready_a = ($urandom_range(0, 1) == 1);
      start_a = (cyc == 20);
      if (tvalid_a && tready_a) beats.push_back({tuser_a, tlast_a, tdata_a});
      held = tvalid_a && !tready_a;
      held_val = {tuser_a, tlast_a, tdata_a};
      tick();
    end
    start_a = 1'b0;
    checks++;
    if (beats.size() != 32) begin errors++; $display("FAIL bp_beat_count: got %0d expected 32", beats.size()); end
    for (int k = 0; k < beats.size(); k++) begin
      checks++;
      if (beats[k] !== exp_a(mem_a[k / 8], k)) begin
        errors++; $display("FAIL bp_beat %0d: got %h expected %h", k, beats[k], exp_a(mem_a[k / 8], k));
      end
    end
    checks++;
    if (rd_cnt != 4 || done_at < 0) begin errors++; $display("FAIL bp_rd_done: got rd %0d done %0d expected rd 4", rd_cnt, done_at); end
    tready_a = 1'b1;
  endtask

  task automatic test_scaled();
    mem_b[0] = 8'hF0; mem_b[1] = 8'h0F; mem_b[2] = 8'hAA; mem_b[3] = 8'h55;
    run_b();
    checks++;
    if (beats.size() != 128) begin errors++; $display("FAIL scaled_beat_count: got %0d expected 128", beats.size()); end
    for (int k = 0; k < beats.size(); k++) begin
      checks++;
      if (beats[k] !== exp_b(k)) begin errors++; $display("FAIL scaled_beat %0d: got %h expected %h", k, beats[k], exp_b(k)); end
    end
    checks++;
    if (rd_cnt != 4) begin errors++; $display("FAIL scaled_rd_pulses: got %0d expected 4", rd_cnt); end
    checks++;
    if (done_at < 0 || done_at != last_at + 1) begin
      errors++; $display("FAIL scaled_frame_done: got %0d expected %0d", done_at, last_at + 1);
    end
  endtask

  task automatic test_gridlines();
    for (int i = 0; i < 4; i++) mem_b[i] = 8'hFF;
    run_b();
    checks++;
    if (beats.size() != 128) begin errors++; $display("FAIL grid_beat_count: got %0d expected 128", beats.size()); end
    for (int k = 0; k < beats.size(); k++) begin
      checks++;
      if (beats[k] !== exp_b(k)) begin errors++; $display("FAIL grid_beat %0d: got %h expected %h", k, beats[k], exp_b(k)); end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int dones;
    for (int i = 0; i < 4; i++) mem_a[i] = 8'h81;
    tready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      if (tvalid_a && tready_a) n++;
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({tvalid_a, tuser_a, tlast_a, busy_a, done_a, rd_en_a, tdata_a} !== 30'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", {tvalid_a, tuser_a, tlast_a, busy_a, done_a, rd_en_a, tdata_a});
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_a || tvalid_a) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", dones); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({rd_en_a, addr_a} !== 3'b100) begin errors++; $display("FAIL restart_fetch: got %b expected 100", {rd_en_a, addr_a}); end
    for (int i = 0; i < 10 && !tvalid_a; i++) tick();
    checks++;
    if ({tvalid_a, tuser_a, tdata_a} !== {1'b1, 1'b1, ALIVE}) begin
      errors++; $display("FAIL restart_first_beat: got %h expected %h", {tvalid_a, tuser_a, tdata_a}, {1'b1, 1'b1, ALIVE});
    end
    for (int i = 0; i < 100 && !done_a; i++) tick();
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", done_a); end
    tick();
  endtask

  task automatic test_back_to_back();
    int d, t;
    for (int i = 0; i < 4; i++) mem_a[i] = 8'h81;
    tready_a = 1'b1;
    start_a = 1'b1;
    tick();
    d = -1; t = -1;
    for (int cyc = 0; cyc < 300 && t < 0; cyc++) begin
      checks++;
      if (busy_a !== !done_a) begin errors++; $display("FAIL b2b_busy cyc %0d: got %b expected %b", cyc, busy_a, !done_a); end
      if (done_a && d < 0) d = cyc;
      if (d >= 0 && cyc > d && tvalid_a && tuser_a) t = cyc;
      tick();
    end
    start_a = 1'b0;
    checks++;
    if (d < 0 || t < 0 || (t - d - 1) != L + 2) begin
      errors++; $display("FAIL b2b_gap: got done %0d tuser %0d expected gap %0d", d, t, L + 2);
    end
    for (int i = 0; i < 200 && !done_a; i++) tick();
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", done_a); end
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_backpressure();
    test_scaled();
    test_gridlines();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
